// File: rtl/reset_sequencer_if.sv
// Reset-sequencer handshake bundle: software request, quiesce handshake, domain resets, status.
// The master modport is the sequencer; the slave modport is the system it controls.
interface reset_sequencer_if #(
    parameter int N_DOMAINS = 4
);
    logic                 soft_rst_req;
    logic                 quiesce_ack;
    logic                 quiesce_req;
    logic [N_DOMAINS-1:0] domain_rst_n;
    logic                 seq_busy;
    logic                 seq_done;
    logic                 timeout_err;

    modport master (
        input  soft_rst_req,
        input  quiesce_ack,
        output quiesce_req,
        output domain_rst_n,
        output seq_busy,
        output seq_done,
        output timeout_err
    );

    modport slave (
        output soft_rst_req,
        output quiesce_ack,
        input  quiesce_req,
        input  domain_rst_n,
        input  seq_busy,
        input  seq_done,
        input  timeout_err
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staggered reset release for N_DOMAINS domains, with software re-reset through a
// quiesce handshake (bounded by a timeout) and a DFT bypass of the domain resets.
module reset_sequencer #(
    parameter int N_DOMAINS       = 4,
    parameter int GAP_CYCLES      = 8,
    parameter int QUIESCE_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              test_mode,
    reset_sequencer_if.master bus
);
    localparam int MAX_CNT = (GAP_CYCLES > QUIESCE_TIMEOUT) ? GAP_CYCLES : QUIESCE_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(N_DOMAINS);

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(QUIESCE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DOMAINS - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        QUIESCE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_DOMAINS-1:0] rel_q, rel_d;
    logic                 qreq_q, qreq_d;
    logic                 done_q, done_d;
    logic                 terr_q, terr_d;
    // High from the first edge that samples reset_n=1; that edge itself is the
    // HOLD entry point, so counting starts on the following edge.
    logic                 started_q;

    // NOTE: every always_comb output gets a default first so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        qreq_d  = qreq_q;
        done_d  = 1'b0;
        terr_d  = terr_q;

        unique case (state_q)
            HOLD: begin
                rel_d = '0;
                if (started_q) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d  = RELEASE;
                        cnt_d    = '0;
                        rel_d[0] = 1'b1;
                        idx_d    = IW'(1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d        = '0;
                    rel_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (bus.soft_rst_req) begin
                    state_d = QUIESCE;
                    cnt_d   = '0;
                    qreq_d  = 1'b1;
                end
            end

            QUIESCE: begin
                // A simultaneous ack wins over the timeout and leaves timeout_err alone.
                if (bus.quiesce_ack || (cnt_q == TMO_LAST)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    qreq_d  = 1'b0;
                    rel_d   = '0;
                    if (!bus.quiesce_ack) begin
                        terr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = HOLD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rel_q     <= '0;
            qreq_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rel_q     <= rel_d;
            qreq_q    <= qreq_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            started_q <= 1'b1;
        end
    end

    // Bypass is a pure mux on registered releases, so functional mode stays glitch-free.
    assign bus.domain_rst_n = test_mode ? {N_DOMAINS{reset_n}} : rel_q;
    assign bus.quiesce_req  = qreq_q;
    assign bus.seq_busy     = (state_q != RUN);
    assign bus.seq_done     = done_q;
    assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each stimulus step queues the values expected
// at absolute edge numbers; a negedge monitor pops and compares them.
module tb_reset_sequencer;
    localparam int N_DOMAINS = 4;

    typedef enum int {SIG_DOM, SIG_QREQ, SIG_BUSY, SIG_DONE, SIG_TERR} sig_e;

    typedef struct {
        int    cyc;
        sig_e  sig;
        int    exp;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic test_mode;
    int   edge_no = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    reset_sequencer_if #(.N_DOMAINS(N_DOMAINS)) bus ();

    reset_sequencer #(
        .N_DOMAINS      (N_DOMAINS),
        .GAP_CYCLES     (8),
        .QUIESCE_TIMEOUT(256)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .test_mode(test_mode),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int observe(input sig_e s);
        case (s)
            SIG_DOM:  return int'(bus.domain_rst_n);
            SIG_QREQ: return int'(bus.quiesce_req);
            SIG_BUSY: return int'(bus.seq_busy);
            SIG_DONE: return int'(bus.seq_done);
            default:  return int'(bus.timeout_err);
        endcase
    endfunction

    task automatic exp_at(input int cyc, input sig_e s, input int v, input string name);
        exp_t e;
        e.cyc = cyc;
        e.sig = s;
        e.exp = v;
        e.tag = $sformatf("%s@%0d", name, cyc);
        sb.push_back(e);
    endtask

    // Edge N's outputs are observed at the negedge that follows it.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_no) begin
                check(sb[i].tag, observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int c);
        while (edge_no < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_soft(input int c);
        wait_until(c - 1);
        bus.soft_rst_req = 1'b1;
        wait_until(c);
        bus.soft_rst_req = 1'b0;
    endtask

    task automatic pulse_ack(input int c);
        wait_until(c - 1);
        bus.quiesce_ack = 1'b1;
        wait_until(c);
        bus.quiesce_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: edge %0d reached, expected end of run", edge_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s, t, e3, f, tm;
        reset_n          = 1'b0;
        test_mode        = 1'b0;
        bus.soft_rst_req = 1'b0;
        bus.quiesce_ack  = 1'b0;

        exp_at(2, SIG_DOM, 'h0, "rst_dom");
        exp_at(2, SIG_QREQ, 0, "rst_qreq");
        exp_at(2, SIG_BUSY, 1, "rst_busy");
        exp_at(2, SIG_DONE, 0, "rst_done");
        exp_at(2, SIG_TERR, 0, "rst_terr");
        wait_until(3);
        reset_n = 1'b1;
        e0 = 4;

        // Power-up release, with requests that must be ignored.
        exp_at(e0 + 7,  SIG_DOM, 'h0, "pu_dom");
        exp_at(e0 + 8,  SIG_DOM, 'h1, "pu_dom");
        exp_at(e0 + 15, SIG_DOM, 'h1, "pu_dom");
        exp_at(e0 + 16, SIG_DOM, 'h3, "pu_dom");
        exp_at(e0 + 24, SIG_DOM, 'h7, "pu_dom");
        exp_at(e0 + 31, SIG_DOM, 'h7, "pu_dom");
        exp_at(e0 + 32, SIG_DOM, 'hf, "pu_dom");
        exp_at(e0 + 31, SIG_DONE, 0, "pu_done");
        exp_at(e0 + 32, SIG_DONE, 1, "pu_done");
        exp_at(e0 + 33, SIG_DONE, 0, "pu_done");
        exp_at(e0 + 31, SIG_BUSY, 1, "pu_busy");
        exp_at(e0 + 32, SIG_BUSY, 0, "pu_busy");
        exp_at(e0 + 13, SIG_QREQ, 0, "ign_qreq");
        exp_at(e0 + 37, SIG_QREQ, 0, "ign_ack_qreq");
        exp_at(e0 + 37, SIG_BUSY, 0, "ign_ack_busy");
        exp_at(e0 + 37, SIG_DOM, 'hf, "ign_ack_dom");
        pulse_soft(e0 + 12);
        pulse_soft(e0 + 20);
        pulse_ack(e0 + 36);

        // Soft reset acknowledged five edges after the request.
        s = e0 + 45;
        exp_at(s - 1,  SIG_QREQ, 0, "sr_qreq");
        exp_at(s,      SIG_QREQ, 1, "sr_qreq");
        exp_at(s + 4,  SIG_QREQ, 1, "sr_qreq");
        exp_at(s + 5,  SIG_QREQ, 0, "sr_qreq");
        exp_at(s,      SIG_BUSY, 1, "sr_busy");
        exp_at(s + 4,  SIG_DOM, 'hf, "sr_dom");
        exp_at(s + 5,  SIG_DOM, 'h0, "sr_dom");
        exp_at(s + 12, SIG_DOM, 'h0, "sr_dom");
        exp_at(s + 13, SIG_DOM, 'h1, "sr_dom");
        exp_at(s + 21, SIG_DOM, 'h3, "sr_dom");
        exp_at(s + 29, SIG_DOM, 'h7, "sr_dom");
        exp_at(s + 37, SIG_DOM, 'hf, "sr_dom");
        exp_at(s + 37, SIG_DONE, 1, "sr_done");
        exp_at(s + 37, SIG_TERR, 0, "sr_terr");
        pulse_soft(s);
        pulse_ack(s + 5);

        // Quiesce timeout, then a level request held across the next RUN entry.
        t = s + 50;
        exp_at(t,       SIG_QREQ, 1, "to_qreq");
        exp_at(t + 255, SIG_QREQ, 1, "to_qreq");
        exp_at(t + 256, SIG_QREQ, 0, "to_qreq");
        exp_at(t + 255, SIG_DOM, 'hf, "to_dom");
        exp_at(t + 256, SIG_DOM, 'h0, "to_dom");
        exp_at(t + 255, SIG_TERR, 0, "to_terr");
        exp_at(t + 256, SIG_TERR, 1, "to_terr");
        exp_at(t + 288, SIG_DOM, 'hf, "to_dom");
        exp_at(t + 288, SIG_DONE, 1, "to_done");
        exp_at(t + 288, SIG_TERR, 1, "to_terr");
        exp_at(t + 288, SIG_BUSY, 0, "lvl_busy");
        exp_at(t + 289, SIG_BUSY, 1, "lvl_busy");
        exp_at(t + 289, SIG_QREQ, 1, "lvl_qreq");
        exp_at(t + 289, SIG_DOM, 'hf, "lvl_dom");
        exp_at(t + 291, SIG_DOM, 'h0, "lvl_dom");
        exp_at(t + 291, SIG_QREQ, 0, "lvl_qreq");
        pulse_soft(t);
        wait_until(t + 279);
        bus.soft_rst_req = 1'b1;
        wait_until(t + 289);
        bus.soft_rst_req = 1'b0;
        pulse_ack(t + 291);

        // Reset asserted mid-release, then a full restart.
        e3 = t + 291;
        exp_at(e3 + 8,  SIG_DOM, 'h1, "mr_dom");
        exp_at(e3 + 16, SIG_DOM, 'h3, "mr_dom");
        exp_at(e3 + 19, SIG_DOM, 'h3, "mr_dom");
        exp_at(e3 + 20, SIG_DOM, 'h0, "mr_dom");
        exp_at(e3 + 19, SIG_TERR, 1, "mr_terr");
        exp_at(e3 + 20, SIG_TERR, 0, "mr_terr");
        f = e3 + 23;
        exp_at(f + 7, SIG_DOM, 'h0, "mr_dom");
        exp_at(f + 8, SIG_DOM, 'h1, "mr_dom");
        exp_at(f + 8, SIG_BUSY, 1, "mr_busy");
        exp_at(f + 8, SIG_QREQ, 0, "mr_qreq");
        wait_until(e3 + 19);
        reset_n = 1'b0;
        wait_until(e3 + 22);
        reset_n = 1'b1;

        // DFT bypass: domain resets follow reset_n within the same cycle.
        tm = f + 40;
        wait_until(tm);
        test_mode = 1'b1;
        exp_at(tm, SIG_DOM, 'hf, "tm_dom");
        exp_at(tm, SIG_BUSY, 0, "tm_busy");
        wait_until(tm + 1);
        reset_n = 1'b0;
        exp_at(tm + 1, SIG_DOM, 'h0, "tm_dom");
        exp_at(tm + 1, SIG_BUSY, 0, "tm_busy");
        exp_at(tm + 2, SIG_BUSY, 1, "tm_busy");
        wait_until(tm + 3);
        reset_n = 1'b1;
        exp_at(tm + 3, SIG_DOM, 'hf, "tm_dom");
        exp_at(tm + 3, SIG_BUSY, 1, "tm_busy");
        wait_until(tm + 4);
        test_mode = 1'b0;
        exp_at(tm + 4,  SIG_DOM, 'h0, "tm_dom");
        exp_at(tm + 11, SIG_DOM, 'h0, "tm_dom");
        exp_at(tm + 12, SIG_DOM, 'h1, "tm_dom");
        wait_until(tm + 20);

        check("sb_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 4, number of sequenced reset domains (range 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 8, clk cycles between successive domain releases (range 1..255).
REQ-003 SHALL have parameter QUIESCE_TIMEOUT, default 256, maximum cycles to wait for quiesce_ack (range 2..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port test_mode  input  1  DFT bypass; when high, outputs follow reset_n directly.
REQ-007 SHALL have port soft_rst_req  input  1  level request for a software re-reset of all domains.
REQ-008 SHALL have port quiesce_ack  input  1  all domains are idle and safe to reset.
REQ-009 SHALL have port quiesce_req  output  1  request to the domains to drain traffic.
REQ-010 SHALL have port domain_rst_n  output  N_DOMAINS  per-domain reset, active-low.
REQ-011 SHALL have port seq_busy  output  1  high whenever the FSM is not in RUN.
REQ-012 SHALL have port seq_done  output  1  one-cycle pulse when the last domain is released.
REQ-013 SHALL have port timeout_err  output  1  sticky flag: a quiesce timeout occurred.

Function
REQ-014 SHALL implement the FSM states HOLD, RELEASE, RUN, QUIESCE.
REQ-015 SHALL use these reset values: state HOLD, domain_rst_n all 0, quiesce_req 0, seq_busy 1, seq_done 0, timeout_err 0, counters 0.
REQ-016 SHALL, in HOLD, keep all domains in reset and count GAP_CYCLES cycles, then enter RELEASE.
REQ-017 SHALL, in RELEASE, raise domain_rst_n[k] in ascending order, one domain every GAP_CYCLES cycles.
REQ-018 SHALL time releases so that, if E0 is the edge that leaves HOLD's entry point, domain_rst_n[k] rises at edge E0 + GAP_CYCLES*(k+1); the entry point is the first edge sampling reset_n=1, or the quiesce-complete edge.
REQ-019 SHALL, once a domain is released, keep it released until the next HOLD entry; there SHALL be no glitches on domain_rst_n.
REQ-020 SHALL assert seq_done for exactly one cycle, coincident with the first cycle domain_rst_n[N_DOMAINS-1] is high, and SHALL enter RUN at that edge.
REQ-021 SHALL, in RUN, sample soft_rst_req at each edge; if it is high, enter QUIESCE and assert quiesce_req from that edge.
REQ-022 SHALL ignore soft_rst_req in every state other than RUN.
REQ-023 SHALL keep soft_rst_req level-sensitive: if it is still high on RUN entry, a new sequence starts at the next edge.
REQ-024 SHALL consider quiesce_ack only in QUIESCE; the ack therefore takes effect no earlier than one edge after quiesce_req rises, and ack in any other state is ignored.
REQ-025 SHALL, in QUIESCE, on the edge sampling quiesce_ack=1: drop quiesce_req, drive all domain_rst_n to 0 simultaneously, and enter HOLD.
REQ-026 SHALL apply a timeout in QUIESCE: if QUIESCE_TIMEOUT cycles elapse without ack, it behaves as if ack were received at that edge and sets timeout_err.
REQ-027 SHALL treat an ack and a timeout arriving on the same edge as an ack; timeout_err is not set in that case.
REQ-028 SHALL clear timeout_err only by reset_n.
REQ-029 SHALL, when test_mode=1, drive domain_rst_n combinationally to {N_DOMAINS{reset_n}} while the FSM runs unaffected; quiesce_req, seq_done and seq_busy are not bypassed.
REQ-030 SHALL size counters at ceil(log2(max(GAP_CYCLES, QUIESCE_TIMEOUT)+1)) bits; counters SHALL never wrap, being cleared on each state transition.

Reset
REQ-031 SHALL, when reset_n=0 is sampled at any edge, in any state, return every register to its REQ-015 value at that edge.
REQ-032 SHALL abort any in-progress QUIESCE or RELEASE on reset without waiting for quiesce_ack.
REQ-033 SHALL restart the full sequence from HOLD when reset_n is released.

Verification (N_DOMAINS=4, GAP_CYCLES=8, QUIESCE_TIMEOUT=256)
REQ-034 SHALL be verified for power-up: reset_n high at edge 0 -> domain_rst_n = 0001 at edge 8, 0011 at 16, 0111 at 24, 1111 at 32; seq_done high for the single cycle after edge 32; seq_busy low from edge 32.
REQ-035 SHALL be verified for soft reset with ack: soft_rst_req at edge S, quiesce_ack at edge S+5 -> quiesce_req high during edges S..S+5; domain_rst_n = 0000 at S+5; re-release at S+13, S+21, S+29, S+37.
REQ-036 SHALL be verified for timeout: soft_rst_req at edge S with quiesce_ack held low -> at edge S+256, domain_rst_n = 0000, timeout_err = 1, quiesce_req = 0; timeout_err remains 1 after the next release completes.
REQ-037 SHALL be verified for mid-sequence reset: reset_n low at edge 20 (domains 0011) -> 0000 at edge 20; after reset_n high, the sequence restarts with domain 0 eight cycles later.
REQ-038 SHALL be verified for ignored requests: soft_rst_req pulses during RELEASE and quiesce_ack pulses in RUN -> no state change; domain_rst_n is unaffected.
REQ-039 SHALL be verified for test_mode: test_mode=1, reset_n toggled -> domain_rst_n = 1111/0000 tracking reset_n in the same cycle, independent of FSM state.
